serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 19 +
 rtl/serial_subtractor_full_subtractor.sv | 35 +++
 rtl/serial_subtractor.sv | 168 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor slice.
//   - ST_IDLE / ST_RUN / ST_DONE : FSM state encodings
//   - state_e                    : typed FSM state built on those encodings
// ----------------------------------------------------------------------------
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
//   Gate-level one-bit full subtractor: in_a - in_b - in_bor.
//   Built from two half-subtractor stages whose borrows are ORed.
//   Ports:
//     in_a    : minuend bit
//     in_b    : subtrahend bit
//     in_bor  : incoming borrow
//     out_d   : difference bit
//     out_bor : outgoing borrow
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic in_a,
    input  logic in_b,
    input  logic in_bor,
    output logic out_d,
    output logic out_bor
);

    logic hs1_d_s;
    logic hs1_bor_s;
    logic hs2_bor_s;

    // First half subtractor: a - b
    assign hs1_d_s   = in_a ^ in_b;
    assign hs1_bor_s = ~in_a & in_b;

    // Second half subtractor: (a - b) - bor
    assign out_d     = hs1_d_s ^ in_bor;
    assign hs2_bor_s = ~hs1_d_s & in_bor;

    // Either stage borrowing means the whole cell borrows
    assign out_bor   = hs1_bor_s | hs2_bor_s;

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing a - b one bit per clock, LSB
//   first, through a single full_subtractor cell and a borrow flip-flop.
//   Operands are accepted on an in_valid/in_ready handshake; the difference and
//   flags are offered on an out_valid/out_ready handshake.
//   Result appears WIDTH cycles after the accept edge; with out_ready held high
//   one result is produced every WIDTH+2 cycles.
//   Parameters:
//     WIDTH      : operand/result width, legal range 2..32
//   Ports:
//     clk        : rising-edge clock
//     reset      : synchronous active-high reset
//     in_valid   : operands present on in_a / in_b
//     in_ready   : block can accept operands (IDLE)
//     in_a       : minuend
//     in_b       : subtrahend
//     out_valid  : result registers hold a completed result (DONE)
//     out_ready  : consumer accepts the result
//     out_d      : (a - b) mod 2^WIDTH
//     out_borrow : unsigned borrow, 1 iff a < b
//     out_ovf    : two's-complement overflow
//     out_zero   : out_d == 0
// ----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_borrow,
    output logic             out_ovf,
    output logic             out_zero
);

    // $clog2(WIDTH) bits always reach WIDTH-1 for WIDTH >= 2
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic               a_msb_r;
    logic               b_msb_r;
    logic               bor_r;
    logic [CNT_W-1:0]   cnt_r;
    // Only WIDTH-1 partial bits are ever stored; the final bit is combined in
    // res_next_s on the last RUN edge and goes straight to out_d_r.
    logic [WIDTH-2:0]   res_r;

    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_d_r;
    logic               out_borrow_r;
    logic               out_ovf_r;
    logic               out_zero_r;

    logic               d_bit_s;
    logic               bor_next_s;
    logic [WIDTH-1:0]   res_next_s;

    full_subtractor u_full_subtractor (
        .in_a    (a_sh_r[0]),
        .in_b    (b_sh_r[0]),
        .in_bor  (bor_r),
        .out_d   (d_bit_s),
        .out_bor (bor_next_s)
    );

    // Result register after this bit shifts in from the MSB end
    always_comb begin
        res_next_s = {d_bit_s, res_r};
    end

    // Handshake FSM, serial datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            a_sh_r       <= {WIDTH{1'b0}};
            b_sh_r       <= {WIDTH{1'b0}};
            a_msb_r      <= 1'b0;
            b_msb_r      <= 1'b0;
            bor_r        <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            res_r        <= {(WIDTH-1){1'b0}};
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_d_r      <= {WIDTH{1'b0}};
            out_borrow_r <= 1'b0;
            out_ovf_r    <= 1'b0;
            out_zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r     <= in_a;
                        b_sh_r     <= in_b;
                        a_msb_r    <= in_a[WIDTH-1];
                        b_msb_r    <= in_b[WIDTH-1];
                        bor_r      <= 1'b0;
                        cnt_r      <= {CNT_W{1'b0}};
                        res_r      <= {(WIDTH-1){1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end else begin
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end

                RUN: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    bor_r  <= bor_next_s;
                    res_r  <= res_next_s[WIDTH-1:1];
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        out_d_r      <= res_next_s;
                        out_borrow_r <= bor_next_s;
                        // Overflow only when operand signs differ and the
                        // result sign disagrees with the minuend sign.
                        out_ovf_r    <= (a_msb_r != b_msb_r) && (d_bit_s != a_msb_r);
                        out_zero_r   <= (res_next_s == {WIDTH{1'b0}});
                        out_valid_r  <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        out_valid_r  <= 1'b0;
                    end
                end

                DONE: begin
                    // Outputs hold; in_ready rises only after this handshake
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                    end
                end

                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_d      = out_d_r;
    assign out_borrow = out_borrow_r;
    assign out_ovf    = out_ovf_r;
    assign out_zero   = out_zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_d;
    logic             out_borrow;
    logic             out_ovf;
    logic             out_zero;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bor;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs [9];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_d      (out_d),
        .out_borrow (out_borrow),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for in_ready, hand over operands, then check the latency.
    task automatic start_txn(input logic [7:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_a     = 8'h00;
        in_b     = 8'h00;
        check("in_ready_in_run", {31'd0, in_ready}, 32'd0);
        repeat (WIDTH - 1) step();
        check("out_valid_not_early", {31'd0, out_valid}, 32'd0);
        step();
        check("out_valid_at_latency", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [7:0] d,
                                input logic bor, input logic ovf, input logic zero);
        check({tag, "_d"},    {24'd0, out_d},      {24'd0, d});
        check({tag, "_bor"},  {31'd0, out_borrow}, {31'd0, bor});
        check({tag, "_ovf"},  {31'd0, out_ovf},    {31'd0, ovf});
        check({tag, "_zero"}, {31'd0, out_zero},   {31'd0, zero});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b1;

        vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0, 1'b0};

        step();
        step();
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();

        // Table-driven vectors with out_ready held high
        for (int i = 0; i < 9; i++) begin
            start_txn(vecs[i].a, vecs[i].b);
            check_result($sformatf("vec%0d", i), vecs[i].d, vecs[i].bor,
                         vecs[i].ovf, vecs[i].zero);
            check("done_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            check("handshake_out_valid", {31'd0, out_valid}, 32'd0);
            check("handshake_in_ready",  {31'd0, in_ready},  32'd1);
            check("handshake_d_held",    {24'd0, out_d},     {24'd0, vecs[i].d});
        end

        // Backpressure: result must hold while new operands toggle
        out_ready = 1'b0;
        start_txn(8'h5A, 8'h0F);
        check_result("bp", 8'h4B, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_a     = (k % 2 == 0) ? 8'h01 : 8'hFE;
            in_b     = (k % 2 == 0) ? 8'hF0 : 8'h0F;
            step();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
            check("bp_d_stable",  {24'd0, out_d},     32'h4B);
            check("bp_bor_stable", {31'd0, out_borrow}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
        check("bp_release_d_held",    {24'd0, out_d},     32'h4B);

        // Reset on the 4th RUN cycle aborts the operation
        in_a     = 8'hFF;
        in_b     = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check_result("abort", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (WIDTH + 2) begin
            step();
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end

        start_txn(8'h10, 8'h20);
        check_result("post_abort", 8'hF0, 1'b1, 1'b0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
